// File: rtl/arb_req_queue_pkg.sv
// Shared definitions for the per-client arbiter request queue:
// FSM state encoding, default data width and a counter-width helper.
package arb_req_queue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 8;

    // Width of a counter holding 0..n; a zero bound still gets one bit.
    function automatic int cnt_w(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/arb_req_queue_fifo.sv
// Synchronous FIFO with power-of-two depth; the count carries one extra bit
// so that full and empty stay distinct after the pointers wrap.
module arb_req_queue_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_next,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CW'(1);
        else if (pop && !push)
            count_next = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/arb_req_queue.sv
// Per-client request queue in front of the two-client arbiter: buffers words,
// requests the channel, pops one word per qualified grant and caps burst length.
module arb_req_queue
    import arb_req_queue_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int GAP_CYC   = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_wr_valid,
    input  logic [DATA_W-1:0]       i_wr_data,
    output logic                    o_wr_ready,
    output logic                    o_req,
    input  logic                    i_gnt,
    output logic [DATA_W-1:0]       o_data,
    output logic                    o_xfer,
    output logic [$clog2(DEPTH):0]  o_count,
    output state_t                  dbg_state
);
    localparam int BW = cnt_w(MAX_BURST);
    localparam int GW = cnt_w(GAP_CYC);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t            state;
    logic              req;
    logic [BW-1:0]     burst_cnt;
    logic [GW-1:0]     gap_cnt;
    logic              push;
    logic              xfer;
    logic              full;
    logic              empty;
    logic              burst_last;
    logic [DATA_W-1:0] head;
    logic [CW-1:0]     count_next;

    // Grants are only honoured while our own registered request is up, which
    // filters out grants the arbiter still holds from an earlier round.
    assign push       = i_wr_valid & ~full & ~i_rst;
    assign xfer       = i_gnt & req & ~empty & ~i_rst;
    assign burst_last = (MAX_BURST != 0) &&
                        (burst_cnt == BW'((MAX_BURST > 0) ? MAX_BURST - 1 : 0));

    assign o_wr_ready = ~full;
    assign o_req      = req;
    assign o_xfer     = xfer;
    assign o_data     = xfer ? head : '0;
    assign dbg_state  = state;

    arb_req_queue_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (i_clk),
        .rst        (i_rst),
        .push       (push),
        .pop        (xfer),
        .wr_data    (i_wr_data),
        .head       (head),
        .count      (o_count),
        .count_next (count_next),
        .full       (full),
        .empty      (empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            req       <= 1'b0;
            burst_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (count_next != '0) begin
                        state <= ST_ACTIVE;
                        req   <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    // The burst cap wins over going idle so a capped burst always gaps.
                    if (xfer) begin
                        if (burst_last) begin
                            state     <= ST_GAP;
                            req       <= 1'b0;
                            burst_cnt <= '0;
                            gap_cnt   <= '0;
                        end else if (count_next == '0) begin
                            state     <= ST_IDLE;
                            req       <= 1'b0;
                            burst_cnt <= '0;
                        end else if (MAX_BURST != 0) begin
                            burst_cnt <= burst_cnt + BW'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(GAP_CYC - 1)) begin
                        gap_cnt <= '0;
                        if (count_next != '0) begin
                            state <= ST_ACTIVE;
                            req   <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            req   <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb_req_queue.sv
// Directed bench for arb_req_queue with default parameters
// (DATA_W=8, DEPTH=8, MAX_BURST=4, GAP_CYC=1).
module tb_arb_req_queue;
    import arb_req_queue_pkg::*;

    logic        i_clk;
    logic        i_rst;
    logic        i_wr_valid;
    logic [7:0]  i_wr_data;
    logic        o_wr_ready;
    logic        o_req;
    logic        i_gnt;
    logic [7:0]  o_data;
    logic        o_xfer;
    logic [3:0]  o_count;
    state_t      dbg_state;

    int          passed = 0;
    int          total  = 0;
    logic [7:0]  exp_q[$];

    arb_req_queue dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wr_valid (i_wr_valid),
        .i_wr_data  (i_wr_data),
        .o_wr_ready (o_wr_ready),
        .o_req      (o_req),
        .i_gnt      (i_gnt),
        .o_data     (o_data),
        .o_xfer     (o_xfer),
        .o_count    (o_count),
        .dbg_state  (dbg_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Advance to 1 ns past the next rising edge; inputs change only there.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_wr_valid = 1'b1; i_wr_data = 8'h33; i_gnt = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (o_req !== 1'b0 || o_count !== 4'd0 || o_wr_ready !== 1'b1 || o_xfer !== 1'b0)
                $display("FAIL reset_outputs: req=%b count=%0d ready=%b xfer=%b, want 0/0/1/0",
                         o_req, o_count, o_wr_ready, o_xfer);
            else passed++;
        end
        i_rst = 1'b0; i_wr_valid = 1'b0;
        tick();
        total++;
        if (o_count !== 4'd0 || o_req !== 1'b0 || dbg_state !== ST_IDLE)
            $display("FAIL reset_no_push: count=%0d req=%b state=%0d, want 0/0/0",
                     o_count, o_req, dbg_state);
        else passed++;
    endtask

    task automatic test_single_word();
        i_wr_valid = 1'b1; i_wr_data = 8'hA5;
        tick();
        i_wr_valid = 1'b0;
        total++;
        if (o_req !== 1'b1 || o_count !== 4'd1)
            $display("FAIL single_req: req=%b count=%0d, want 1/1", o_req, o_count);
        else passed++;
        tick();
        i_gnt = 1'b1;
        #1;
        total++;
        if (o_xfer !== 1'b1 || o_data !== 8'hA5)
            $display("FAIL single_xfer: xfer=%b data=%h, want 1/a5", o_xfer, o_data);
        else passed++;
        tick();
        total++;
        if (o_req !== 1'b0 || o_count !== 4'd0 || o_xfer !== 1'b0)
            $display("FAIL single_after: req=%b count=%0d xfer=%b, want 0/0/0",
                     o_req, o_count, o_xfer);
        else passed++;
        i_gnt = 1'b0;
    endtask

    task automatic test_fill_drain();
        int pulses;
        logic [7:0] exp;
        exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            i_wr_valid = 1'b1; i_wr_data = 8'(i);
            #1;
            total++;
            if (o_wr_ready !== (i < 8))
                $display("FAIL fill_ready_%0d: ready=%b, want %b", i, o_wr_ready, (i < 8));
            else passed++;
            if (i < 8) exp_q.push_back(8'(i));
            tick();
        end
        i_wr_valid = 1'b0;
        total++;
        if (o_count !== 4'd8 || o_wr_ready !== 1'b0)
            $display("FAIL fill_full: count=%0d ready=%b, want 8/0", o_count, o_wr_ready);
        else passed++;
        i_gnt = 1'b1;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (o_xfer === 1'b1) begin
                pulses++;
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL drain_extra: data=%h, want no transfer", o_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (o_data !== exp)
                        $display("FAIL drain_order: data=%h, want %h", o_data, exp);
                    else passed++;
                end
            end
            tick();
        end
        i_gnt = 1'b0;
        total++;
        if (pulses != 8 || o_count !== 4'd0)
            $display("FAIL drain_total: pulses=%0d count=%0d, want 8/0", pulses, o_count);
        else passed++;
    endtask

    task automatic test_burst_cap();
        bit exp_x[8];
        bit exp_r[8];
        int k;
        exp_x = '{1, 1, 1, 1, 0, 1, 1, 0};
        exp_r = '{1, 1, 1, 1, 0, 1, 1, 0};
        for (int i = 0; i < 6; i++) begin
            i_wr_valid = 1'b1; i_wr_data = 8'h10 + 8'(i);
            tick();
        end
        i_wr_valid = 1'b0;
        i_gnt = 1'b1;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            total++;
            if (o_xfer !== exp_x[c] || o_req !== exp_r[c])
                $display("FAIL burst_cycle_%0d: xfer=%b req=%b, want %b/%b",
                         c, o_xfer, o_req, exp_x[c], exp_r[c]);
            else passed++;
            if (exp_x[c]) begin
                total++;
                if (o_data !== 8'h10 + 8'(k))
                    $display("FAIL burst_data_%0d: data=%h, want %h", k, o_data, 8'h10 + 8'(k));
                else passed++;
                k++;
            end
            tick();
        end
        i_gnt = 1'b0;
    endtask

    task automatic test_stale_grant();
        int n;
        i_gnt = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if (o_xfer !== 1'b0)
                $display("FAIL stale_empty_%0d: xfer=%b, want 0", c, o_xfer);
            else passed++;
            tick();
        end
        i_wr_valid = 1'b1; i_wr_data = 8'h5A;
        #1;
        total++;
        if (o_xfer !== 1'b0 || o_req !== 1'b0)
            $display("FAIL stale_push_cycle: xfer=%b req=%b, want 0/0", o_xfer, o_req);
        else passed++;
        tick();
        i_wr_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (o_xfer === 1'b1) begin
                n++;
                total++;
                if (o_req !== 1'b1 || o_data !== 8'h5A)
                    $display("FAIL stale_xfer: req=%b data=%h, want 1/5a", o_req, o_data);
                else passed++;
            end
            tick();
        end
        i_gnt = 1'b0;
        total++;
        if (n != 1)
            $display("FAIL stale_count: xfers=%0d, want 1", n);
        else passed++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            i_wr_valid = 1'b1; i_wr_data = 8'h20 + 8'(i);
            tick();
        end
        i_wr_data = 8'h23; i_gnt = 1'b1;
        #1;
        total++;
        if (o_xfer !== 1'b1 || o_data !== 8'h20)
            $display("FAIL b2b_xfer: xfer=%b data=%h, want 1/20", o_xfer, o_data);
        else passed++;
        tick();
        i_wr_valid = 1'b0;
        total++;
        if (o_count !== 4'd3)
            $display("FAIL b2b_count: count=%0d, want 3", o_count);
        else passed++;
        #1;
        total++;
        if (o_xfer !== 1'b1 || o_data !== 8'h21)
            $display("FAIL b2b_second: xfer=%b data=%h, want 1/21", o_xfer, o_data);
        else passed++;
        i_rst = 1'b1;
        #1;
        total++;
        if (o_xfer !== 1'b0)
            $display("FAIL rst_mid_xfer: xfer=%b, want 0", o_xfer);
        else passed++;
        tick();
        i_rst = 1'b0; i_gnt = 1'b0;
        total++;
        if (o_count !== 4'd0 || dbg_state !== ST_IDLE || o_req !== 1'b0 || o_wr_ready !== 1'b1)
            $display("FAIL rst_mid_state: count=%0d state=%0d req=%b ready=%b, want 0/0/0/1",
                     o_count, dbg_state, o_req, o_wr_ready);
        else passed++;
        i_gnt = 1'b1;
        #1;
        total++;
        if (o_xfer !== 1'b0)
            $display("FAIL rst_after_gnt: xfer=%b, want 0", o_xfer);
        else passed++;
        tick();
        i_gnt = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_wr_valid = 1'b0; i_wr_data = '0; i_gnt = 1'b0;
        test_reset();
        test_single_word();
        test_fill_drain();
        test_burst_cap();
        test_stale_grant();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
